// File: rtl/imem_loader.sv
// imem_loader: streams a byte-serial program image into instruction memory
// while the fetch stage is frozen, packing bytes little-endian into 32-bit
// words, then redirects fetch to BOOT_PC through a one-cycle IF/ID flush.
module imem_loader #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 1024,
  parameter logic [XLEN-1:0] BOOT_PC    = {XLEN{1'b0}},
  localparam int             AW         = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW:0]     word_count,
  input  logic            s_valid,
  input  logic [7:0]      s_data,
  output logic            s_ready,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_waddr,
  output logic [31:0]     imem_wdata,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            pc_src,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Depth expressed in the word_count width so the overflow compare is exact.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(IMEM_DEPTH);

  state_t          state_r;
  state_t          state_s;
  logic [AW:0]     wc_r;
  logic [AW-1:0]   word_idx_r;
  logic [1:0]      byte_cnt_r;
  logic [31:0]     pack_r;
  logic            err_r;
  logic            byte_accept_s;
  logic [AW:0]     idx_next_s;

  assign byte_accept_s = s_valid && s_ready;
  assign idx_next_s    = {1'b0, word_idx_r} + {{AW{1'b0}}, 1'b1};

  // The packing register holds the word only while it is written, and the
  // address comes straight from the word index, zero-extended, never truncated.
  assign imem_wdata = pack_r;
  assign imem_waddr = {{(XLEN - AW - 2){1'b0}}, word_idx_r, 2'b00};
  assign err        = err_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: start is only honoured in IDLE, LOAD leaves on the
  // fourth accepted byte, WRITE returns to LOAD until the last word is stored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (word_count > DEPTH_W) begin
            state_s = ST_DONE;
          end else if (word_count == {(AW + 1){1'b0}}) begin
            state_s = ST_FLUSH;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (byte_accept_s && (byte_cnt_r == 2'd3)) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (idx_next_s == wc_r) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_FLUSH: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Datapath: latch the request at start, pack bytes little-endian, and
  // advance the word index once per completed write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc_r       <= {(AW + 1){1'b0}};
      word_idx_r <= {AW{1'b0}};
      byte_cnt_r <= 2'd0;
      pack_r     <= 32'd0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            wc_r       <= word_count;
            err_r      <= (word_count > DEPTH_W);
            word_idx_r <= {AW{1'b0}};
            byte_cnt_r <= 2'd0;
          end
        end
        ST_LOAD: begin
          if (byte_accept_s) begin
            pack_r[{byte_cnt_r, 3'b000} +: 8] <= s_data;
            byte_cnt_r                        <= byte_cnt_r + 2'd1;
          end
        end
        ST_WRITE: begin
          word_idx_r <= word_idx_r + {{(AW - 1){1'b0}}, 1'b1};
        end
        default: begin
          wc_r <= wc_r;
        end
      endcase
    end
  end

  // Control outputs are registered from the next state, so each one is
  // already valid during the first cycle of the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready     <= 1'b0;
      imem_we     <= 1'b0;
      pc_write    <= 1'b1;
      ifid_write  <= 1'b1;
      ifid_flush  <= 1'b0;
      pc_src      <= 1'b0;
      redirect_pc <= {XLEN{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      s_ready     <= (state_s == ST_LOAD);
      imem_we     <= (state_s == ST_WRITE);
      pc_write    <= (state_s == ST_IDLE) || (state_s == ST_DONE);
      ifid_write  <= (state_s == ST_IDLE);
      ifid_flush  <= (state_s == ST_FLUSH);
      pc_src      <= (state_s == ST_FLUSH) || (state_s == ST_DONE);
      redirect_pc <= ((state_s == ST_FLUSH) || (state_s == ST_DONE)) ? BOOT_PC : {XLEN{1'b0}};
      busy        <= (state_s == ST_LOAD) || (state_s == ST_WRITE) || (state_s == ST_FLUSH);
      done        <= (state_s == ST_DONE);
    end
  end

endmodule
